// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sequencer.
package parking_pkg;

    localparam int DEF_CNT_W    = 5;
    localparam int DEF_CAPACITY = 16;

    // Synchronized sensor pattern {a,b}
    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_OUT  = 2'b10;
    localparam logic [1:0] S_BOTH = 2'b11;
    localparam logic [1:0] S_IN   = 2'b01;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ENT1 = 3'd1,
        ENT2 = 3'd2,
        ENT3 = 3'd3,
        EXT1 = 3'd4,
        EXT2 = 3'd5,
        EXT3 = 3'd6,
        ERR  = 3'd7
    } state_t;

endpackage

// File: rtl/parking_gate_controller_sensor_sync.sv
// Two-flop synchronizer with synchronous active-high reset.
module sensor_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/parking_gate_controller.sv
// Decodes car entry/exit from beam-break order and pulses the occupancy counter.
// state | meaning
// IDLE  | both beams clear
// ENT1  | entering, outer blocked
// ENT2  | entering, both blocked
// ENT3  | entering, inner blocked only
// EXT1  | exiting, inner blocked
// EXT2  | exiting, both blocked
// EXT3  | exiting, outer blocked only
// ERR   | illegal transition seen, waiting for both beams clear
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int CAPACITY = DEF_CAPACITY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic [CNT_W-1:0] count,
    output logic             incr,
    output logic             decr,
    output logic             full,
    output logic             empty,
    output logic             seq_err,
    output logic             reject
);

    logic [1:0] w_s;
    logic       w_room;
    logic       w_incr, w_decr, w_rej, w_err;
    state_t     w_next;
    state_t     r_state;
    logic       r_incr, r_decr, r_rej, r_err;

    sensor_sync #(.W(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({a, b}),
        .o_q   (w_s)
    );

    assign w_room = count < CNT_W'(CAPACITY);
    assign full   = count >= CNT_W'(CAPACITY);
    assign empty  = count == '0;

    always_comb begin
        w_next = r_state;
        w_incr = 1'b0;
        w_decr = 1'b0;
        w_rej  = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE: case (w_s)
                S_OUT:   w_next = ENT1;
                S_IN:    w_next = EXT1;
                S_BOTH:  begin w_next = ERR; w_err = 1'b1; end
                default: ;
            endcase
            ENT1: case (w_s)
                S_BOTH:  w_next = ENT2;
                S_NONE:  w_next = IDLE;
                S_IN:    begin w_next = ERR; w_err = 1'b1; end
                default: ;
            endcase
            ENT2: case (w_s)
                S_IN:    w_next = ENT3;
                S_OUT:   w_next = ENT1;
                S_NONE:  begin w_next = ERR; w_err = 1'b1; end
                default: ;
            endcase
            ENT3: case (w_s)
                S_NONE:  begin
                    w_next = IDLE;
                    w_incr = w_room;
                    w_rej  = !w_room;
                end
                S_BOTH:  w_next = ENT2;
                S_OUT:   begin w_next = ERR; w_err = 1'b1; end
                default: ;
            endcase
            EXT1: case (w_s)
                S_BOTH:  w_next = EXT2;
                S_NONE:  w_next = IDLE;
                S_OUT:   begin w_next = ERR; w_err = 1'b1; end
                default: ;
            endcase
            EXT2: case (w_s)
                S_OUT:   w_next = EXT3;
                S_IN:    w_next = EXT1;
                S_NONE:  begin w_next = ERR; w_err = 1'b1; end
                default: ;
            endcase
            EXT3: case (w_s)
                S_NONE:  begin
                    w_next = IDLE;
                    w_decr = !empty;
                    w_rej  = empty;
                end
                S_BOTH:  w_next = EXT2;
                S_IN:    begin w_next = ERR; w_err = 1'b1; end
                default: ;
            endcase
            ERR: if (w_s == S_NONE) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_incr  <= 1'b0;
            r_decr  <= 1'b0;
            r_rej   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_incr  <= w_incr;
            r_decr  <= w_decr;
            r_rej   <= w_rej;
            r_err   <= w_err;
        end
    end

    assign incr    = r_incr;
    assign decr    = r_decr;
    assign reject  = r_rej;
    assign seq_err = r_err;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with a simple occupancy counter.
module tb_parking_gate_controller;
    import parking_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       a, b;
    logic [4:0] count;
    logic       incr, decr, full, empty, seq_err, reject;

    logic [4:0] cnt_dir;
    logic [4:0] cnt_int;
    logic       integ;
    logic       cnt_clr;

    int total = 0;
    int bad   = 0;
    int n_incr = 0, n_decr = 0, n_rej = 0, n_err = 0;
    int n_multi = 0, n_wide = 0;
    logic p_incr = 0, p_decr = 0, p_rej = 0, p_err = 0;
    int b_incr, b_decr, b_rej, b_err;

    always #5 clk = ~clk;

    assign count = integ ? cnt_int : cnt_dir;

    parking_gate_controller dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .count   (count),
        .incr    (incr),
        .decr    (decr),
        .full    (full),
        .empty   (empty),
        .seq_err (seq_err),
        .reject  (reject)
    );

    // Occupancy counter reacting to the controller's pulses
    always @(posedge clk) begin
        if (cnt_clr)   cnt_int <= 5'd0;
        else if (incr) cnt_int <= cnt_int + 5'd1;
        else if (decr) cnt_int <= cnt_int - 5'd1;
    end

    always @(negedge clk) begin
        if (incr)    n_incr++;
        if (decr)    n_decr++;
        if (reject)  n_rej++;
        if (seq_err) n_err++;
        if ((int'(incr) + int'(decr) + int'(reject) + int'(seq_err)) > 1) n_multi++;
        if ((incr && p_incr) || (decr && p_decr) || (reject && p_rej) || (seq_err && p_err)) n_wide++;
        p_incr = incr; p_decr = decr; p_rej = reject; p_err = seq_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        {a, b} = ab;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_incr = n_incr; b_decr = n_decr; b_rej = n_rej; b_err = n_err;
    endtask

    task automatic check_delta(input string tag, input int di, input int dd, input int dr, input int de);
        check({tag, "_incr"},   n_incr - b_incr, di);
        check({tag, "_decr"},   n_decr - b_decr, dd);
        check({tag, "_reject"}, n_rej - b_rej,   dr);
        check({tag, "_seqerr"}, n_err - b_err,   de);
    endtask

    task automatic entry();
        hold(2'b10, 5); hold(2'b11, 5); hold(2'b01, 5); hold(2'b00, 5);
    endtask

    task automatic exit_car();
        hold(2'b01, 5); hold(2'b11, 5); hold(2'b10, 5); hold(2'b00, 5);
    endtask

    initial begin
        reset = 1'b1; a = 0; b = 0; integ = 0; cnt_clr = 1'b1; cnt_dir = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_pulses", {incr, decr, reject, seq_err}, 0);
        check("rst_state", dut.r_state, IDLE);
        cnt_dir = 5'd16;
        #1;
        check("rst_full16", full, 1);
        check("rst_empty16", empty, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cnt_clr = 1'b0;

        // Entry with exact pulse timing
        cnt_dir = 5'd3;
        hold(2'b00, 5);
        snap();
        hold(2'b10, 5); hold(2'b11, 5); hold(2'b01, 5);
        {a, b} = 2'b00;
        @(posedge clk); #1; check("ent_t_n", incr, 0);
        @(posedge clk); #1; check("ent_t_n1", incr, 0);
        @(posedge clk); #1; check("ent_t_n2", incr, 1);
        @(posedge clk); #1; check("ent_t_n3", incr, 0);
        hold(2'b00, 2);
        check_delta("entry", 1, 0, 0, 0);

        // Exit, then two aborted entries
        snap();
        exit_car();
        check_delta("exit", 0, 1, 0, 0);
        snap();
        hold(2'b10, 5); hold(2'b00, 5);
        check("abort1_state", dut.r_state, IDLE);
        hold(2'b10, 5); hold(2'b11, 5); hold(2'b10, 5); hold(2'b00, 5);
        check("abort2_state", dut.r_state, IDLE);
        check_delta("abort", 0, 0, 0, 0);

        // Range rejects
        cnt_dir = 5'd16;
        snap();
        entry();
        check_delta("full_rej", 0, 0, 1, 0);
        check("full_flag", full, 1);
        cnt_dir = 5'd0;
        snap();
        exit_car();
        check_delta("empty_rej", 0, 0, 1, 0);
        check("empty_flag", empty, 1);

        // Illegal transitions
        cnt_dir = 5'd5;
        snap();
        hold(2'b11, 5);
        check("err_state", dut.r_state, ERR);
        hold(2'b11, 5); hold(2'b01, 5);
        check_delta("illegal1", 0, 0, 0, 1);
        hold(2'b00, 5);
        check("err_recover", dut.r_state, IDLE);
        snap();
        entry();
        check_delta("post_err_entry", 1, 0, 0, 0);
        snap();
        hold(2'b10, 5); hold(2'b01, 5); hold(2'b00, 5);
        check_delta("illegal2", 0, 0, 0, 1);

        // Reset in the middle of an entry
        snap();
        hold(2'b10, 5); hold(2'b11, 5);
        reset = 1'b1;
        {a, b} = 2'b01;
        @(posedge clk); #1;
        check("midrst_outs", {incr, decr, reject, seq_err}, 0);
        check("midrst_state", dut.r_state, IDLE);
        reset = 1'b0;
        hold(2'b01, 5); hold(2'b00, 5);
        check_delta("midrst", 0, 0, 0, 0);

        // Integration with the counter
        integ = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("int_start", cnt_int, 0);
        snap();
        for (int i = 0; i < 20; i++) entry();
        check_delta("int_fill", 16, 0, 4, 0);
        check("int_cnt16", cnt_int, 16);
        check("int_full", full, 1);
        snap();
        for (int i = 0; i < 20; i++) exit_car();
        check_delta("int_drain", 0, 16, 4, 0);
        check("int_cnt0", cnt_int, 0);
        check("int_empty", empty, 1);

        check("one_hot_pulses", n_multi, 0);
        check("pulse_width", n_wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
